rot_shift_pipe: RTL
===================

Name: rot_shift_pipe

Overview:
- Parametrised, pipelined rotate/shift unit; successor to the fixed 4-bit combinational rotator.
- Operates on WIDTH-bit operands and supports rotate left/right plus logical and arithmetic shifts.
- Produces carry-out and zero flags.
- Uses valid/ready handshakes on both sides, with one pipeline stage per shift-amount bit, so it can sit directly in the datapath between an operand source and the ALU result bus.

Parameters:
- WIDTH, 8, operand width in bits. Must be a power of 2 and at least 4.
- AW, $clog2(WIDTH), shift-amount width and pipeline stage count. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_data  input  WIDTH  operand A
- in_amt  input  AW  shift/rotate amount, 0..WIDTH-1
- in_op  input  3  operation: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA; 101–111 illegal
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  result
- out_carry  output  1  last bit shifted out (shifts) or last bit wrapped (rotates)
- out_zero  output  1  out_data == 0
- out_err  output  1  beat carried an illegal op

Behaviour:
- Reset:
  - Asserting rst_n low immediately clears every stage valid bit.
  - out_valid, out_data, out_carry, out_zero and out_err all go to 0.
  - Reset mid-operation discards all in-flight beats; no partial result is ever emitted.
  - in_ready is 1 from the first cycle after reset deasserts.
- Transfers:
  - An input transfer occurs when in_valid && in_ready on a rising edge.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - AW register stages; stage k applies a conditional shift/rotate by 2^k, controlled by amt[k].
  - Stage AW-1 drives the out_* ports directly from registers.
- Latency and ordering:
  - Latency is exactly AW cycles from input transfer to out_valid when no stall occurs.
  - Throughput is 1 beat/cycle.
  - Beats leave in order.
- Elastic flow control:
  - Stage k loads when it is empty or its contents move forward this cycle.
  - in_ready = !v[0] || advance[0]. This is a combinational chain from out_ready; no skid buffer is required.
- Capacity and data stability:
  - The pipeline holds AW beats.
  - While out_ready is low and all stages are full, in_ready = 0 and nothing is lost or duplicated.
  - Data is held stable while out_valid && !out_ready.
- Operation semantics (n = in_amt):
  - ROL: (A<<n)|(A>>(WIDTH-n)).
  - ROR: (A>>n)|(A<<(WIDTH-n)).
  - SLL: zero fill from the LSB side.
  - SRL: zero fill from the MSB side.
  - SRA: MSB of A replicated into vacated positions.
- Carry (computed at stage 0 from in_data/in_amt, then carried alongside the data):
  - n = 0: carry = 0 for all ops.
  - ROL: carry = result[0].
  - ROR: carry = result[WIDTH-1].
  - SLL: carry = A[WIDTH-n].
  - SRL and SRA: carry = A[n-1].
- Zero flag: out_zero = (out_data == 0), registered with the data.
- Illegal ops (101–111):
  - Data passes through unmodified, with carry = 0 and out_err = 1.
  - The beat still occupies a slot and follows normal flow control.
- Other boundaries:
  - Amount 0 is a pass-through.
  - Amount WIDTH-1 is the maximum; no amount can reach or exceed WIDTH.
  - A simultaneous input and output transfer with the pipe full is legal and sustains full throughput.

Decomposition:
- Shared package rot_pkg holds:
  - the op encodings as localparams OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA;
  - a stage payload struct with fields data, amt, op, carry, err.
- One sub-module, rot_stage:
  - parameters WIDTH and K;
  - one conditional shift by 2^K, the valid register and the advance logic;
  - instantiated AW times via generate.
- Flag and carry computation is kept in the top level.

Test Plan:
- WIDTH=8, A=0x96:
  - ROL n=3 -> out_data=0xB4, carry=0, zero=0, exactly 3 cycles after acceptance.
  - ROR n=1 -> 0x4B, carry=0.
- A=0x96:
  - SRA n=2 -> 0xE5, carry=1.
  - SLL n=4 -> 0x60, carry=1.
  - SRL n=7 -> 0x01, carry=0.
- A=0x80, SLL n=1 -> out_data=0x00, zero=1, carry=1. Then op=110 with A=0x5A -> out_data=0x5A, err=1, carry=0.
- Stream of 6 beats with out_ready=0:
  - 3 beats are accepted, then in_ready=0.
  - Release out_ready -> all 6 results emerge in order, values correct, no gaps once streaming.
- Random out_ready toggling over 1000 random beats (all ops, all amounts): results match a reference model, order is preserved, and out_data is stable while stalled.
- Assert rst_n low with 3 beats in flight -> out_valid drops asynchronously, all outputs are 0, and no stale beat appears after release.

Source files
------------

// File: rtl/rot_shift_pipe_pkg.sv
// Shared definitions for the pipelined rotate/shift unit: op encodings and
// the payload that travels down the stage chain alongside each valid bit.
package rot_pkg;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // Payload is sized for the widest supported operand; narrower instances
  // use the low WIDTH data bits and the low AW amount bits.
  localparam int MAX_WIDTH = 64;
  localparam int MAX_AW    = 6;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
    logic [MAX_AW-1:0]    amt;
    logic [2:0]           op;
    logic                 carry;
    logic                 err;
  } rot_payload_t;

  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_SRA;
  endfunction

endpackage

// File: rtl/rot_shift_pipe_if.sv
// Operand-side and result-side valid/ready bundle for rot_shift_pipe.
interface rot_shift_pipe_if #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
endinterface

// File: rtl/rot_shift_pipe_stage.sv
// One pipeline stage: conditionally shifts/rotates by 2^K when amt[K] is set,
// and holds its beat until the next stage (or the result bus) takes it.
module rot_stage
  import rot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  rot_payload_t up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output rot_payload_t dn_data
);
  localparam int S = 1 << K;

  logic             vld;
  rot_payload_t     q;
  rot_payload_t     nxt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] r;
  logic             unused_hi;

  assign a         = up_data.data[WIDTH-1:0];
  assign unused_hi = ^up_data.data;

  // Load when empty or when the held beat leaves this cycle.
  assign up_ready = !vld || dn_ready;
  assign dn_valid = vld;
  assign dn_data  = q;

  // Conditional shift by 2^K; illegal ops pass the data through untouched.
  always_comb begin
    r = a;
    if (up_data.amt[K]) begin
      case (up_data.op)
        OP_ROL:  r = (a << S) | (a >> (WIDTH - S));
        OP_ROR:  r = (a >> S) | (a << (WIDTH - S));
        OP_SLL:  r = a << S;
        OP_SRL:  r = a >> S;
        OP_SRA:  r = WIDTH'($signed(a) >>> S);
        default: r = a;
      endcase
    end
    nxt = up_data;
    nxt.data = '0;
    nxt.data[WIDTH-1:0] = r;
  end

  // Stage register; payload only captured when a real beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (up_ready) begin
      vld <= up_valid;
      if (up_valid) q <= nxt;
    end
  end

endmodule

// File: rtl/rot_shift_pipe.sv
// Pipelined rotate/shift unit: AW elastic stages, one per amount bit.
// Carry and the illegal-op flag are resolved on entry and ride with the data.
module rot_shift_pipe
  import rot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  rot_shift_pipe_if.slave bus
);
  localparam int AW = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("rot_shift_pipe: WIDTH must be a power of 2 in 4..64");
  end

  logic [AW-1:0] idx_wrap;
  logic [AW-1:0] idx_low;
  logic          carry0;
  rot_payload_t  p_in;
  rot_payload_t  p [0:AW];
  logic [AW:0]   v;
  logic [AW:0]   rdy;
  logic          unused_tail;

  // Bit that ends up leaving the word: A[WIDTH-n] for left ops, A[n-1] for right ops.
  assign idx_wrap = AW'(0) - bus.in_amt;
  assign idx_low  = bus.in_amt - AW'(1);

  // Entry carry; amount 0 and illegal ops never produce a carry.
  always_comb begin
    carry0 = 1'b0;
    if (bus.in_amt != '0) begin
      case (bus.in_op)
        OP_ROL, OP_SLL:         carry0 = bus.in_data[idx_wrap];
        OP_ROR, OP_SRL, OP_SRA: carry0 = bus.in_data[idx_low];
        default:                carry0 = 1'b0;
      endcase
    end
  end

  // Pack the incoming beat into the stage payload.
  always_comb begin
    p_in = '0;
    p_in.data[WIDTH-1:0] = bus.in_data;
    p_in.amt[AW-1:0]     = bus.in_amt;
    p_in.op              = bus.in_op;
    p_in.carry           = carry0;
    p_in.err             = op_illegal(bus.in_op);
  end

  assign p[0]         = p_in;
  assign v[0]         = bus.in_valid;
  assign bus.in_ready = rdy[0];
  assign rdy[AW]      = bus.out_ready;

  for (genvar k = 0; k < AW; k++) begin : g_stage
    rot_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (v[k]),
      .up_ready (rdy[k]),
      .up_data  (p[k]),
      .dn_valid (v[k+1]),
      .dn_ready (rdy[k+1]),
      .dn_data  (p[k+1])
    );
  end

  // Outputs come straight from the last stage register; zero is gated by valid
  // so an idle or freshly reset unit reports zero=0.
  assign bus.out_valid = v[AW];
  assign bus.out_data  = p[AW].data[WIDTH-1:0];
  assign bus.out_carry = p[AW].carry;
  assign bus.out_err   = p[AW].err;
  assign bus.out_zero  = v[AW] && (p[AW].data[WIDTH-1:0] == '0);

  // Amount/op are consumed by the time a beat reaches the output.
  assign unused_tail = ^{p[AW].amt, p[AW].op, p[AW].data};

endmodule
